// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the state type of the
// iterative shift-and-add multiplier that borrows the ALU.
package alu_pkg;

  localparam logic [3:0] ALU_OP_AND  = 4'b0000;
  localparam logic [3:0] ALU_OP_OR   = 4'b0001;
  localparam logic [3:0] ALU_OP_ADD  = 4'b0010;
  localparam logic [3:0] ALU_OP_XOR  = 4'b0011;
  localparam logic [3:0] ALU_OP_SLL  = 4'b0100;
  localparam logic [3:0] ALU_OP_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OP_SUB  = 4'b0110;
  localparam logic [3:0] ALU_OP_SLLI = 4'b0111;
  localparam logic [3:0] ALU_OP_SRA  = 4'b1000;
  localparam logic [3:0] ALU_OP_SLT  = 4'b1001;
  localparam logic [3:0] ALU_OP_SLTU = 4'b1010;
  localparam logic [3:0] ALU_OP_SRLI = 4'b1011;
  localparam logic [3:0] ALU_OP_SRAI = 4'b1100;
  localparam logic [3:0] ALU_OP_BEQ  = 4'b1101;
  localparam logic [3:0] ALU_OP_BLT  = 4'b1110;
  localparam logic [3:0] ALU_OP_BGE  = 4'b1111;

  // Iteration counter width; must hold the value DATA_WIDTH itself.
  localparam int MUL_COUNT_WIDTH = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ITER  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Bundle between the multiplier and its parent: operand/result handshake
// plus the borrowed-ALU request/grant port.
interface alu_mul_seq_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) ();

  // Handshakes: a transfer happens on a rising edge where both sides are
  // high. Start/Ready accepts operands; ResultValid/ResultReady hands back
  // the product, and Result/ResultValid stay stable until taken. AluReq
  // asks for the ALU; the ALU step completes only on an edge with AluGrant.
  logic                     Start;
  logic                     Ready;
  logic [DATA_WIDTH-1:0]    OpA;
  logic [DATA_WIDTH-1:0]    OpB;
  logic [DATA_WIDTH-1:0]    Result;
  logic                     ResultValid;
  logic                     ResultReady;
  logic                     AluReq;
  logic                     AluGrant;
  logic [DATA_WIDTH-1:0]    AluSrcA;
  logic [DATA_WIDTH-1:0]    AluSrcB;
  logic [OPCODE_LENGTH-1:0] AluOperation;
  logic [DATA_WIDTH-1:0]    AluResult;

  modport slave (
    input  Start, OpA, OpB, ResultReady, AluGrant, AluResult,
    output Ready, Result, ResultValid, AluReq, AluSrcA, AluSrcB, AluOperation
  );

  modport master (
    output Start, OpA, OpB, ResultReady, AluGrant, AluResult,
    input  Ready, Result, ResultValid, AluReq, AluSrcA, AluSrcB, AluOperation
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative MUL (low word) via shift-and-add on the shared ALU.
// Optional macro ALU_MUL_EARLY_TERM_EN stops once the multiplier runs out of set bits.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_mul_seq_if.slave bus,
  output mul_state_t dbg_state
);

  localparam int CW = MUL_COUNT_WIDTH;
  localparam logic [CW-1:0] LAST_COUNT = CW'(DATA_WIDTH);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = OPCODE_LENGTH'(ALU_OP_ADD);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLLI = OPCODE_LENGTH'(ALU_OP_SLLI);
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  mul_state_t state;

  logic [DATA_WIDTH-1:0]    acc;
  logic [DATA_WIDTH-1:0]    mcand;
  logic [DATA_WIDTH-1:0]    mplier;
  logic [CW-1:0]            count;

  logic                     ready;
  logic                     result_valid;
  logic [DATA_WIDTH-1:0]    result;
  logic                     alu_req;
  logic [DATA_WIDTH-1:0]    alu_src_a;
  logic [DATA_WIDTH-1:0]    alu_src_b;
  logic [OPCODE_LENGTH-1:0] alu_op;

  logic                     iter_done;

`ifdef ALU_MUL_EARLY_TERM_EN
  assign iter_done = (count == LAST_COUNT) || (mplier == '0);
`else
  assign iter_done = (count == LAST_COUNT);
`endif

  // Outputs are registered: each transition loads the values the
  // destination state presents, so they are stable for the whole state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      count        <= '0;
      ready        <= 1'b1;
      result_valid <= 1'b0;
      result       <= '0;
      alu_req      <= 1'b0;
      alu_src_a    <= '0;
      alu_src_b    <= '0;
      alu_op       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            acc    <= '0;
            mcand  <= bus.OpA;
            mplier <= bus.OpB;
            count  <= '0;
            ready  <= 1'b0;
            state  <= ITER;
          end
        end

        ITER: begin
          if (iter_done) begin
            result       <= acc;
            result_valid <= 1'b1;
            state        <= DONE;
          end else if (mplier[0]) begin
            alu_req   <= 1'b1;
            alu_op    <= OP_ADD;
            alu_src_a <= acc;
            alu_src_b <= mcand;
            state     <= ADD;
          end else begin
            alu_req   <= 1'b1;
            alu_op    <= OP_SLLI;
            alu_src_a <= mcand;
            alu_src_b <= ONE;
            state     <= SHIFT;
          end
        end

        ADD: begin
          // Without a grant nothing moves, so the ALU inputs stay valid.
          if (bus.AluGrant) begin
            acc       <= bus.AluResult;
            alu_op    <= OP_SLLI;
            alu_src_a <= mcand;
            alu_src_b <= ONE;
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          if (bus.AluGrant) begin
            mcand     <= bus.AluResult;
            mplier    <= mplier >> 1;
            count     <= count + CW'(1);
            alu_req   <= 1'b0;
            alu_op    <= '0;
            alu_src_a <= '0;
            alu_src_b <= '0;
            state     <= ITER;
          end
        end

        DONE: begin
          if (bus.ResultReady) begin
            result_valid <= 1'b0;
            ready        <= 1'b1;
            state        <= IDLE;
          end
        end

        default: begin
          state        <= IDLE;
          ready        <= 1'b1;
          result_valid <= 1'b0;
          alu_req      <= 1'b0;
          alu_op       <= '0;
          alu_src_a    <= '0;
          alu_src_b    <= '0;
        end
      endcase
    end
  end

  assign bus.Ready        = ready;
  assign bus.ResultValid  = result_valid;
  assign bus.Result       = result;
  assign bus.AluReq       = alu_req;
  assign bus.AluSrcA      = alu_src_a;
  assign bus.AluSrcB      = alu_src_b;
  assign bus.AluOperation = alu_op;
  assign dbg_state        = state;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: plays the parent (ALU + grant), compares products
// and latencies with a plain-arithmetic reference.
module tb_alu_mul_seq;
  import alu_pkg::*;

  localparam int DW = 32;

  logic       clk;
  logic       rst_n;
  mul_state_t dbg_state;
  int         n_checks;
  int         n_errors;

  alu_mul_seq_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(4)) mif ();

  alu_mul_seq #(.DATA_WIDTH(DW), .OPCODE_LENGTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (mif),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d errors so far, required completion", n_errors);
    $fatal(1, "watchdog");
  end

  // Shared ALU owned by the parent: purely combinational.
  always_comb begin
    mif.AluResult = '0;
    case (mif.AluOperation)
      ALU_OP_ADD:  mif.AluResult = mif.AluSrcA + mif.AluSrcB;
      ALU_OP_SLLI: mif.AluResult = mif.AluSrcA << mif.AluSrcB[4:0];
      default:     mif.AluResult = '0;
    endcase
  end

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] ref_product(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return p[DW-1:0];
  endfunction

  function automatic int ref_latency(input logic [DW-1:0] b, input int stalls);
    int n;
`ifdef ALU_MUL_EARLY_TERM_EN
    n = 0;
    for (int i = 0; i < DW; i++) if (b[i]) n = i + 1;
`else
    n = DW;
`endif
    return 2 + 2 * n + $countones(b) + stalls;
  endfunction

  // ---------------- driver ----------------
  // mode 0: grant always; 1: random grant; 2: deny first ADD for 5 cycles.
  task automatic run_mul(input logic [DW-1:0] a, input logic [DW-1:0] b, input int mode,
                         input bit release_done, output logic [DW-1:0] res, output int lat,
                         output int stalls, output bit timed_out, output bit req_seen,
                         output bit hold_ok);
    int          stall_left;
    bit          grant;
    bit          prev_stalled;
    logic [DW-1:0] prev_a;
    @(negedge clk);
    mif.OpA = a; mif.OpB = b; mif.Start = 1'b1; mif.ResultReady = 1'b0; mif.AluGrant = 1'b1;
    lat = 0; stalls = 0; timed_out = 0; req_seen = 0; hold_ok = 1;
    stall_left = (mode == 2) ? 5 : 0;
    prev_stalled = 0; prev_a = '0;
    @(negedge clk);
    lat = 1;
    mif.Start = 1'b0; mif.OpA = $urandom; mif.OpB = $urandom;
    while (!mif.ResultValid && lat < 400) begin
      if (mif.AluReq) req_seen = 1;
      if (prev_stalled && mif.AluSrcA !== prev_a) hold_ok = 0;
      grant = 1'b1;
      if (mode == 1) grant = ($urandom_range(0, 3) != 0);
      if (mode == 2 && stall_left > 0 && mif.AluReq && mif.AluOperation == ALU_OP_ADD) begin
        grant = 1'b0;
        stall_left--;
      end
      if (mif.AluReq && !grant) stalls++;
      prev_stalled = mif.AluReq && !grant;
      prev_a = mif.AluSrcA;
      mif.AluGrant = grant;
      @(negedge clk);
      lat++;
    end
    mif.AluGrant = 1'b1;
    timed_out = !mif.ResultValid;
    res = mif.Result;
    if (release_done && !timed_out) begin
      mif.ResultReady = 1'b1;
      @(negedge clk);
      mif.ResultReady = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (mif.Ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b expected 1", mif.Ready); end
    n_checks++; if (mif.ResultValid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", mif.ResultValid); end
    n_checks++; if (mif.AluReq !== 1'b0) begin n_errors++; $display("FAIL reset_alureq: got %b expected 0", mif.AluReq); end
    n_checks++; if (mif.Result !== '0) begin n_errors++; $display("FAIL reset_result: got %h expected 0", mif.Result); end
    n_checks++;
    if ({mif.AluSrcA, mif.AluSrcB, mif.AluOperation} !== '0) begin
      n_errors++; $display("FAIL reset_alu_bus: got %h/%h/%h expected 0/0/0", mif.AluSrcA, mif.AluSrcB, mif.AluOperation);
    end
    n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
  endtask

  task automatic test_directed();
    logic [DW-1:0] ta[3];
    logic [DW-1:0] tb[3];
    logic [DW-1:0] res;
    int lat, stalls;
    bit to, req, hold;
    ta[0] = 32'd7;        tb[0] = 32'd6;
    ta[1] = 32'hFFFFFFFF; tb[1] = 32'hFFFFFFFF;
    ta[2] = 32'h1234;     tb[2] = 32'd0;
    for (int i = 0; i < 3; i++) begin
      run_mul(ta[i], tb[i], 0, 1'b1, res, lat, stalls, to, req, hold);
      n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL directed%0d_timeout: got no ResultValid after %0d cycles, expected one", i, lat); end
      n_checks++; if (res !== ref_product(ta[i], tb[i])) begin n_errors++; $display("FAIL directed%0d_result: got %h expected %h", i, res, ref_product(ta[i], tb[i])); end
      n_checks++; if (lat !== ref_latency(tb[i], 0)) begin n_errors++; $display("FAIL directed%0d_latency: got %0d expected %0d", i, lat, ref_latency(tb[i], 0)); end
      n_checks++; if (mif.Ready !== 1'b1) begin n_errors++; $display("FAIL directed%0d_ready_after: got %b expected 1", i, mif.Ready); end
      if (i == 2) begin
`ifdef ALU_MUL_EARLY_TERM_EN
        n_checks++; if (req !== 1'b0) begin n_errors++; $display("FAIL zero_no_alureq: got %b expected 0", req); end
`else
        n_checks++; if (req !== 1'b1) begin n_errors++; $display("FAIL zero_shifts_issued: got %b expected 1", req); end
`endif
      end
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] res;
    int lat, stalls;
    bit to, req, hold;
    run_mul(32'd3, 32'd5, 2, 1'b1, res, lat, stalls, to, req, hold);
    n_checks++; if (res !== 32'd15) begin n_errors++; $display("FAIL stall_result: got %h expected %h", res, 32'd15); end
    n_checks++; if (stalls !== 5) begin n_errors++; $display("FAIL stall_count: got %0d expected 5", stalls); end
    n_checks++; if (lat !== ref_latency(32'd5, 5)) begin n_errors++; $display("FAIL stall_latency: got %0d expected %0d", lat, ref_latency(32'd5, 5)); end
    n_checks++; if (hold !== 1'b1) begin n_errors++; $display("FAIL stall_acc_hold: got %b expected 1", hold); end
  endtask

  task automatic test_random();
    logic [DW-1:0] a, b, res;
    int lat, stalls;
    bit to, req, hold;
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 255)) : DW'($urandom);
      run_mul(a, b, 1, 1'b1, res, lat, stalls, to, req, hold);
      n_checks++; if (res !== ref_product(a, b)) begin n_errors++; $display("FAIL random%0d_result: %h*%h got %h expected %h", i, a, b, res, ref_product(a, b)); end
      n_checks++; if (lat !== ref_latency(b, stalls)) begin n_errors++; $display("FAIL random%0d_latency: got %0d expected %0d", i, lat, ref_latency(b, stalls)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] res;
    int lat, stalls, guard;
    bit to, req, hold;
    @(negedge clk);
    mif.OpA = 32'd5; mif.OpB = 32'd3; mif.Start = 1'b1; mif.AluGrant = 1'b1;
    @(negedge clk);
    mif.Start = 1'b0;
    guard = 0;
    while (dbg_state !== SHIFT && guard < 100) begin @(negedge clk); guard++; end
    n_checks++; if (dbg_state !== SHIFT) begin n_errors++; $display("FAIL midreset_reach_shift: got state %0d expected %0d", dbg_state, SHIFT); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (mif.Ready !== 1'b1) begin n_errors++; $display("FAIL midreset_ready: got %b expected 1", mif.Ready); end
    n_checks++; if (mif.ResultValid !== 1'b0) begin n_errors++; $display("FAIL midreset_valid: got %b expected 0", mif.ResultValid); end
    n_checks++; if (mif.AluReq !== 1'b0) begin n_errors++; $display("FAIL midreset_alureq: got %b expected 0", mif.AluReq); end
    run_mul(32'd9, 32'd9, 0, 1'b1, res, lat, stalls, to, req, hold);
    n_checks++; if (res !== 32'd81) begin n_errors++; $display("FAIL midreset_new_result: got %h expected %h", res, 32'd81); end
    n_checks++; if (lat !== ref_latency(32'd9, 0)) begin n_errors++; $display("FAIL midreset_new_latency: got %0d expected %0d", lat, ref_latency(32'd9, 0)); end
  endtask

  task automatic test_done_hold();
    logic [DW-1:0] res;
    int lat, stalls;
    bit to, req, hold;
    run_mul(32'd6, 32'd7, 0, 1'b0, res, lat, stalls, to, req, hold);
    n_checks++; if (res !== 32'd42) begin n_errors++; $display("FAIL hold_result: got %h expected %h", res, 32'd42); end
    for (int c = 0; c < 3; c++) begin
      mif.Start = (c == 1); mif.OpA = 32'd2; mif.OpB = 32'd2;
      @(negedge clk);
      n_checks++; if (mif.ResultValid !== 1'b1) begin n_errors++; $display("FAIL hold%0d_valid: got %b expected 1", c, mif.ResultValid); end
      n_checks++; if (mif.Result !== 32'd42) begin n_errors++; $display("FAIL hold%0d_result: got %h expected %h", c, mif.Result, 32'd42); end
      n_checks++; if (mif.Ready !== 1'b0) begin n_errors++; $display("FAIL hold%0d_ready: got %b expected 0", c, mif.Ready); end
    end
    mif.Start = 1'b0; mif.ResultReady = 1'b1;
    @(negedge clk);
    mif.ResultReady = 1'b0;
    n_checks++; if (mif.Ready !== 1'b1) begin n_errors++; $display("FAIL hold_release_ready: got %b expected 1", mif.Ready); end
    n_checks++; if (mif.ResultValid !== 1'b0) begin n_errors++; $display("FAIL hold_release_valid: got %b expected 0", mif.ResultValid); end
    @(negedge clk);
    n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL hold_start_ignored: got state %0d expected %0d", dbg_state, IDLE); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0;
    mif.Start = 1'b0; mif.OpA = '0; mif.OpB = '0;
    mif.ResultReady = 1'b0; mif.AluGrant = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_directed();
    test_stall();
    test_random();
    test_reset_mid();
    test_done_hold();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
